// File: rtl/alu_pkg.sv
// Shared ALU result-side definitions: field widths, status flag bit positions
// and the packed capture entry.
package alu_pkg;

   localparam int FUNC_W     = 4;
   localparam int FLAG_W     = 4;
   localparam int ALU_DATA_W = 8;

   localparam int FLAG_ZERO  = 0;
   localparam int FLAG_NEG   = 1;
   localparam int FLAG_CARRY = 2;
   localparam int FLAG_OVF   = 3;

   typedef struct packed {
      logic [FUNC_W-1:0]     func;
      logic [ALU_DATA_W-1:0] f;
      logic [ALU_DATA_W-1:0] x;
      logic [FLAG_W-1:0]     flags;
   } alu_entry_t;

endpackage

// File: rtl/alu_result_buffer_if.sv
// Producer/consumer bundle of the ALU result buffer; the master modport is the
// ALU plus the writeback consumer, the slave modport is the buffer.
interface alu_result_buffer_if #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 8
) ();
   import alu_pkg::*;

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              in_valid;
   logic              in_ready;
   logic [FUNC_W-1:0] function_select;
   logic [DATA_W-1:0] F;
   logic [DATA_W-1:0] X;
   logic              zero;
   logic              neg;
   logic              carry;
   logic              overflow;
   logic              out_valid;
   logic              out_ready;
   logic [FUNC_W-1:0] out_func;
   logic [DATA_W-1:0] out_F;
   logic [DATA_W-1:0] out_X;
   logic [FLAG_W-1:0] out_flags;
   logic [CNT_W-1:0]  count;
   logic              drop_err;
   logic [FLAG_W-1:0] sticky_flags;
   logic              sticky_clr;

   modport master (
      output in_valid, function_select, F, X, zero, neg, carry, overflow,
             out_ready, sticky_clr,
      input  in_ready, out_valid, out_func, out_F, out_X, out_flags, count,
             drop_err, sticky_flags
   );

   modport slave (
      input  in_valid, function_select, F, X, zero, neg, carry, overflow,
             out_ready, sticky_clr,
      output in_ready, out_valid, out_func, out_F, out_X, out_flags, count,
             drop_err, sticky_flags
   );

endinterface

// File: rtl/alu_rb_fifo.sv
// Generic synchronous FIFO: storage, wrapping pointers and occupancy count.
// Callers must only assert i_push when not full and i_pop when not empty.
module alu_rb_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [WIDTH-1:0]           i_data,
   output logic [WIDTH-1:0]           o_data,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_full,
   output logic                       o_empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   // Storage is cleared too so the head outputs read zero out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
         end
         if (i_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/alu_result_buffer.sv
// Result-side capture buffer for the 8-bit ALU: flag packing, drop detection and
// optional sticky flag accumulation (ALU_RESULT_BUFFER_STICKY_EN) around a FIFO.
module alu_result_buffer
   import alu_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   alu_result_buffer_if.slave bus
);
   localparam int ENTRY_W = FUNC_W + 2*DATA_W + FLAG_W;
   localparam int CNT_W   = $clog2(DEPTH) + 1;

   logic [FLAG_W-1:0]  w_in_flags;
   logic [ENTRY_W-1:0] w_wr_data;
   logic [ENTRY_W-1:0] w_rd_data;
   logic [CNT_W-1:0]   w_count;
   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;
   logic               r_drop_err;

   always_comb begin
      w_in_flags             = '0;
      w_in_flags[FLAG_ZERO]  = bus.zero;
      w_in_flags[FLAG_NEG]   = bus.neg;
      w_in_flags[FLAG_CARRY] = bus.carry;
      w_in_flags[FLAG_OVF]   = bus.overflow;
   end

   assign w_wr_data = {bus.function_select, bus.F, bus.X, w_in_flags};

   // Full blocks pushes even when a pop happens in the same cycle.
   assign bus.in_ready  = !rst && !w_full;
   assign bus.out_valid = !w_empty;
   assign w_push        = bus.in_valid && bus.in_ready;
   assign w_pop         = bus.out_valid && bus.out_ready;

   alu_rb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_wr_data),
      .o_data  (w_rd_data),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign bus.out_func  = w_rd_data[ENTRY_W-1 -: FUNC_W];
   assign bus.out_F     = w_rd_data[2*DATA_W+FLAG_W-1 -: DATA_W];
   assign bus.out_X     = w_rd_data[DATA_W+FLAG_W-1 -: DATA_W];
   assign bus.out_flags = w_rd_data[FLAG_W-1:0];
   assign bus.count     = w_count;

   always_ff @(posedge clk) begin
      if (rst) r_drop_err <= 1'b0;
      else     r_drop_err <= bus.in_valid && !bus.in_ready;
   end

   assign bus.drop_err = r_drop_err;

`ifdef ALU_RESULT_BUFFER_STICKY_EN
   logic [FLAG_W-1:0] r_sticky;

   always_ff @(posedge clk) begin
      if (rst)                 r_sticky <= '0;
      else if (bus.sticky_clr) r_sticky <= w_push ? w_in_flags : '0;
      else if (w_push)         r_sticky <= r_sticky | w_in_flags;
   end

   assign bus.sticky_flags = r_sticky;
`else
   logic w_unused_sticky_clr;
   assign w_unused_sticky_clr = bus.sticky_clr;
   assign bus.sticky_flags    = '0;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scenario bench for alu_result_buffer: pops are scored against a queue of
// accepted pushes, per-scenario state is checked inline.
module tb_alu_result_buffer;
   import alu_pkg::*;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 8;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;
   int   n_pop;
   alu_entry_t sb[$];

   alu_result_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

   alu_result_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic set_in(input logic v, input logic [3:0] func,
                         input logic [7:0] f, input logic [7:0] x,
                         input logic [3:0] flags);
      bus.in_valid        = v;
      bus.function_select = func;
      bus.F               = f;
      bus.X               = x;
      bus.zero            = flags[0];
      bus.neg             = flags[1];
      bus.carry           = flags[2];
      bus.overflow        = flags[3];
   endtask

   // One clock: score handshakes at the falling edge, return 1 time unit after
   // the rising edge so inline checks see the post-edge state.
   task automatic tick();
      alu_entry_t e;
      @(negedge clk);
      if (rst) begin
         sb.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            n_vec++;
            n_pop++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL pop_underflow got=%h F=%h required=no-pop", bus.out_func, bus.out_F);
            end else begin
               e = sb.pop_front();
               if ({bus.out_func, bus.out_F, bus.out_X, bus.out_flags} !== e) begin
                  n_err++;
                  $display("FAIL pop_data got=%h/%h/%h/%h required=%h/%h/%h/%h",
                           bus.out_func, bus.out_F, bus.out_X, bus.out_flags,
                           e.func, e.f, e.x, e.flags);
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            e.func  = bus.function_select;
            e.f     = bus.F;
            e.x     = bus.X;
            e.flags = {bus.overflow, bus.carry, bus.neg, bus.zero};
            sb.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(1'b0, 4'h0, 8'h00, 8'h00, 4'h0);
      bus.out_ready  = 1'b0;
      bus.sticky_clr = 1'b0;
      tick();
      tick();
      n_vec++;
      if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got=%b required=0", bus.in_ready); end
      rst = 1'b0;
      tick();
      n_vec++;
      if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_state got count=%0d ov=%b ir=%b required 0/0/1", bus.count, bus.out_valid, bus.in_ready);
      end
      n_vec++;
      if ({bus.out_func, bus.out_F, bus.out_X, bus.out_flags, bus.drop_err, bus.sticky_flags} !== 33'd0) begin
         n_err++;
         $display("FAIL reset_outputs got=%h/%h/%h/%h/%b/%h required all zero",
                  bus.out_func, bus.out_F, bus.out_X, bus.out_flags, bus.drop_err, bus.sticky_flags);
      end
   endtask

   task automatic test_single_push();
      set_in(1'b1, 4'b1000, 8'h39, 8'h00, 4'b0000);
      tick();
      set_in(1'b0, 4'h0, 8'h00, 8'h00, 4'h0);
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_F !== 8'h39 || bus.out_func !== 4'b1000 || bus.count !== 3'd1) begin
         n_err++;
         $display("FAIL single_push got ov=%b F=%h func=%b count=%0d required 1/39/1000/1",
                  bus.out_valid, bus.out_F, bus.out_func, bus.count);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      n_vec++;
      if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
         n_err++;
         $display("FAIL single_drain got ov=%b count=%0d required 0/0", bus.out_valid, bus.count);
      end
   endtask

   task automatic test_fill_drop();
      bus.out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         set_in(1'b1, 4'h2, 8'h10 + 8'(i), 8'hA0 + 8'(i), 4'h0);
         tick();
      end
      n_vec++;
      if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL fill got count=%0d ir=%b required 4/0", bus.count, bus.in_ready);
      end
      set_in(1'b1, 4'hF, 8'hEE, 8'hEE, 4'hF);
      tick();
      n_vec++;
      if (bus.drop_err !== 1'b1 || bus.count !== 3'd4) begin
         n_err++;
         $display("FAIL drop got drop_err=%b count=%0d required 1/4", bus.drop_err, bus.count);
      end
      n_vec++;
      if (bus.sticky_flags !== 4'h0) begin
         n_err++;
         $display("FAIL drop_sticky got=%b required=0000", bus.sticky_flags);
      end
      set_in(1'b0, 4'h0, 8'h00, 8'h00, 4'h0);
      tick();
      n_vec++;
      if (bus.drop_err !== 1'b0) begin n_err++; $display("FAIL drop_pulse got=%b required=0", bus.drop_err); end
   endtask

   task automatic test_full_push_pop();
      set_in(1'b1, 4'h5, 8'h55, 8'h55, 4'h0);
      bus.out_ready = 1'b1;
      tick();
      set_in(1'b0, 4'h0, 8'h00, 8'h00, 4'h0);
      n_vec++;
      if (bus.count !== 3'd3 || bus.out_F !== 8'h11 || bus.drop_err !== 1'b1) begin
         n_err++;
         $display("FAIL full_push_pop got count=%0d F=%h drop=%b required 3/11/1", bus.count, bus.out_F, bus.drop_err);
      end
      for (int i = 0; i < 3; i++) tick();
      bus.out_ready = 1'b0;
      n_vec++;
      if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL full_drain got count=%0d ov=%b required 0/0", bus.count, bus.out_valid);
      end
   endtask

   task automatic test_back_to_back();
      n_pop = 0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_in(1'b1, 4'(i), 8'(i), 8'(9 - i), 4'(i));
         tick();
         n_vec++;
         if (bus.out_valid !== 1'b1 || bus.count !== 3'd1) begin
            n_err++;
            $display("FAIL b2b_flow cycle=%0d got ov=%b count=%0d required 1/1", i, bus.out_valid, bus.count);
         end
      end
      set_in(1'b0, 4'h0, 8'h00, 8'h00, 4'h0);
      tick();
      bus.out_ready = 1'b0;
      n_vec++;
      if (n_pop !== 10 || bus.count !== 3'd0) begin
         n_err++;
         $display("FAIL b2b_total got pops=%0d count=%0d required 10/0", n_pop, bus.count);
      end
   endtask

   task automatic test_sticky();
      logic [3:0] exp_a;
      logic [3:0] exp_b;
`ifdef ALU_RESULT_BUFFER_STICKY_EN
      exp_a = 4'b1100;
      exp_b = 4'b0001;
`else
      exp_a = 4'b0000;
      exp_b = 4'b0000;
`endif
      bus.out_ready  = 1'b1;
      bus.sticky_clr = 1'b1;
      tick();
      bus.sticky_clr = 1'b0;
      n_vec++;
      if (bus.sticky_flags !== 4'b0000) begin n_err++; $display("FAIL sticky_clr got=%b required=0000", bus.sticky_flags); end
      set_in(1'b1, 4'h1, 8'h01, 8'h02, 4'b0100);
      tick();
      set_in(1'b1, 4'h2, 8'h03, 8'h04, 4'b1000);
      tick();
      n_vec++;
      if (bus.sticky_flags !== exp_a) begin n_err++; $display("FAIL sticky_or got=%b required=%b", bus.sticky_flags, exp_a); end
      set_in(1'b1, 4'h3, 8'h05, 8'h06, 4'b0001);
      bus.sticky_clr = 1'b1;
      tick();
      bus.sticky_clr = 1'b0;
      n_vec++;
      if (bus.sticky_flags !== exp_b) begin n_err++; $display("FAIL sticky_clr_push got=%b required=%b", bus.sticky_flags, exp_b); end
      set_in(1'b0, 4'h0, 8'h00, 8'h00, 4'h0);
      tick();
      bus.out_ready = 1'b0;
      n_vec++;
      if (bus.count !== 3'd0 || bus.sticky_flags !== exp_b) begin
         n_err++;
         $display("FAIL sticky_hold got count=%0d sticky=%b required 0/%b", bus.count, bus.sticky_flags, exp_b);
      end
   endtask

   task automatic test_mid_reset();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 4'h6, 8'h60 + 8'(i), 8'h00, 4'h2);
         tick();
      end
      n_vec++;
      if (bus.count !== 3'd3) begin n_err++; $display("FAIL pre_rst_count got=%0d required=3", bus.count); end
      rst = 1'b1;
      set_in(1'b1, 4'h7, 8'h77, 8'h77, 4'h0);
      bus.out_ready = 1'b1;
      tick();
      n_vec++;
      if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL mid_rst got count=%0d ov=%b required 0/0", bus.count, bus.out_valid);
      end
      rst = 1'b0;
      bus.out_ready = 1'b0;
      set_in(1'b1, 4'h9, 8'hA5, 8'h5A, 4'h1);
      tick();
      set_in(1'b0, 4'h0, 8'h00, 8'h00, 4'h0);
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_F !== 8'hA5 || bus.count !== 3'd1) begin
         n_err++;
         $display("FAIL post_rst_head got ov=%b F=%h count=%0d required 1/a5/1", bus.out_valid, bus.out_F, bus.count);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      n_vec++;
      if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL end_empty got sb=%0d ov=%b required 0/0", sb.size(), bus.out_valid);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      n_pop = 0;
      test_reset();
      test_single_push();
      test_fill_drop();
      test_full_push_pop();
      test_back_to_back();
      test_sticky();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Registered capture buffer on the result side of the 8-bit ALU. Each cycle the ALU result is flagged valid, the block stores the function code, F, X and the four status flags in a DEPTH-entry FIFO. A downstream consumer (register-file writeback or debug port) drains the FIFO over a valid/ready handshake. The block optionally keeps sticky flag accumulators across operations.

## Interface
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- DATA_W, 8, width of F and X.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ALU outputs are valid this cycle.
- in_ready  out  1  entry can be accepted; equals !full.
- function_select  in  4  opcode that produced the result; stored as a tag.
- F  in  DATA_W  primary ALU result.
- X  in  DATA_W  secondary ALU result.
- zero, neg, carry, overflow  in  1 each  ALU status flags.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer accepts the head entry.
- out_func  out  4  head opcode tag.
- out_F, out_X  out  DATA_W  head results.
- out_flags  out  4  head flags, bit order {overflow, carry, neg, zero}.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- drop_err  out  1  one-cycle pulse when in_valid=1 and in_ready=0.
- sticky_flags  out  4  OR of all accepted flags since the last clear, same bit order.
- sticky_clr  in  1  clear the sticky flags.

## Operation
- Push: in_valid && in_ready at the clock edge writes {function_select, F, X, flags} at wr_ptr. wr_ptr then increments modulo DEPTH.
- Pop: out_valid && out_ready at the clock edge increments rd_ptr modulo DEPTH.
- Occupancy state:
  - EMPTY when count=0.
  - PARTIAL when 0<count<DEPTH.
  - FULL when count=DEPTH.
- State transitions:
  - Push only: count+1.
  - Pop only: count−1.
  - Push and pop together: count unchanged.
- Full: in_ready=0, even when a pop occurs in the same cycle. There is no push-through-full. A valid input while full is dropped and drop_err pulses.
- Empty: out_valid=0. out_* hold their last value and are don't-care. There is no bypass from input to output.
- Pointer wrap: pointers wrap silently. Full and empty are derived from count, not from pointer equality.
- Sticky flags, updated each cycle:
  - With sticky_clr=1 and a push: sticky_flags <= pushed flags.
  - With sticky_clr=1 and no push: sticky_flags <= 0.
  - Otherwise, on a push: sticky_flags <= sticky_flags | pushed flags.
- Dropped inputs never update the sticky flags.

## Timing
- Reset values:
  - count=0, pointers=0, out_valid=0.
  - in_ready=1 in the cycle after rst deasserts. in_ready=0 while rst=1.
  - out_func=0, out_F=0, out_X=0, out_flags=0.
  - drop_err=0, sticky_flags=0.
- rst asserted mid-operation discards all entries at that edge. Handshakes in that cycle are ignored.
- Latency: a push into EMPTY gives out_valid=1 on the next cycle, with the head data registered.
- Throughput: one push and one pop per cycle, sustained.
- drop_err is registered. It is high in the cycle after the dropped input.
- count, in_ready and out_valid are all register-derived. There is no combinational path from in_valid or out_ready to in_ready or out_valid.

## Configuration
- ALU_RESULT_BUFFER_STICKY_EN defined: sticky flag logic is built as described above.
- ALU_RESULT_BUFFER_STICKY_EN undefined: sticky_flags is tied to 0, sticky_clr is ignored, and no sticky registers are inferred.

## Structure
- Shared package alu_pkg holds:
  - FUNC_W=4 and FLAG_W=4.
  - Flag bit indices FLAG_ZERO=0, FLAG_NEG=1, FLAG_CARRY=2, FLAG_OVF=3.
  - The packed entry type (func, F, X, flags).
- One sub-module, alu_rb_fifo: generic synchronous FIFO holding storage, pointers and count.
- The top level adds flag packing, drop_err and the sticky logic.

## Test plan
- Reset then a single push of func=4'b1000, F=8'h39, X=8'h00, carry=0, zero=0 -> next cycle out_valid=1, out_F=8'h39, out_func=4'b1000, count=1.
- Four back-to-back pushes with out_ready=0 -> count=4, in_ready=0. A fifth push -> dropped, drop_err=1 for one cycle, count stays 4.
- Full FIFO with a push and pop in the same cycle -> push rejected. Pop leaves count=3 and the head advances to entry 2.
- Steady push+pop for 10 cycles with F=0..9 -> outputs 0..9 in order with no gaps, and the pointers wrap twice.
- Push carry=1, then push overflow=1 -> sticky_flags=4'b1100. sticky_clr asserted with a push of zero=1 -> 4'b0001. (Without the macro, sticky_flags stays 0.)
- rst pulsed with count=3 -> next cycle count=0 and out_valid=0. Afterwards the first pushed value appears first.
